// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO read-side UART transmitter, one bit per i_clk.
// Pops a word when free, then sends start, data LSB first, optional parity, stop.
module fifo_uart_tx #(
   parameter int D_SIZE = 8
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_fifo_empty,
   input  logic [D_SIZE-1:0] i_fifo_data,
   input  logic              i_par_en,
   input  logic              i_par_typ,
   output logic              o_fifo_rd_inc,
   output logic              o_tx_out,
   output logic              o_busy
);

   localparam int CW = (D_SIZE > 1) ? $clog2(D_SIZE) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state;
   logic [CW-1:0]       bit_cnt;
   logic [D_SIZE-1:0]   shreg;
   logic                par_en_q;
   logic                parity_q;
   logic                capture;

   // A word may only be taken when idle or on the final stop-bit edge.
   always_comb begin
      capture = 1'b0;
      if (!i_fifo_empty && (state == IDLE || state == STOP))
         capture = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         shreg         <= '0;
         par_en_q      <= 1'b0;
         parity_q      <= 1'b0;
         o_fifo_rd_inc <= 1'b0;
         o_tx_out      <= 1'b1;
         o_busy        <= 1'b0;
      end else begin
         o_fifo_rd_inc <= 1'b0;
         if (capture) begin
            shreg         <= i_fifo_data;
            par_en_q      <= i_par_en;
            parity_q      <= (^i_fifo_data) ^ i_par_typ;
            o_fifo_rd_inc <= 1'b1;
            o_tx_out      <= 1'b0;
            o_busy        <= 1'b1;
            state         <= START;
         end else begin
            case (state)
               IDLE: begin
                  o_tx_out <= 1'b1;
                  o_busy   <= 1'b0;
               end
               START: begin
                  bit_cnt  <= '0;
                  o_tx_out <= shreg[0];
                  shreg    <= shreg >> 1;
                  state    <= DATA;
               end
               DATA: begin
                  if (bit_cnt == CW'(D_SIZE - 1)) begin
                     if (par_en_q) begin
                        o_tx_out <= parity_q;
                        state    <= PARITY;
                     end else begin
                        o_tx_out <= 1'b1;
                        state    <= STOP;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt + CW'(1);
                     o_tx_out <= shreg[0];
                     shreg    <= shreg >> 1;
                  end
               end
               PARITY: begin
                  o_tx_out <= 1'b1;
                  state    <= STOP;
               end
               STOP: begin
                  o_tx_out <= 1'b1;
                  o_busy   <= 1'b0;
                  state    <= IDLE;
               end
               default: begin
                  o_tx_out <= 1'b1;
                  o_busy   <= 1'b0;
                  state    <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx.
// A frame-level model predicts line/busy/pop per cycle; literal frames pin the model.
module tb_fifo_uart_tx;

   typedef struct packed {
      logic tx;
      logic busy;
      logic rd;
   } ent_t;

   localparam ent_t IDLE_E = '{tx: 1'b1, busy: 1'b0, rd: 1'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'h00;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       rd_inc;
   logic       tx_out;
   logic       busy;

   int         checks = 0;
   int         errors = 0;

   logic [7:0] fq[$];
   ent_t       frame_q[$];
   ent_t       exp_e = IDLE_E;

   fifo_uart_tx #(.D_SIZE(8)) dut (
      .i_clk        (clk),
      .i_rstn       (rst_n),
      .i_fifo_empty (fifo_empty),
      .i_fifo_data  (fifo_data),
      .i_par_en     (par_en),
      .i_par_typ    (par_typ),
      .o_fifo_rd_inc(rd_inc),
      .o_tx_out     (tx_out),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Whole frame is laid out as a list of per-cycle line/busy/pop values.
   task automatic build_frame(input logic [7:0] w, input logic pe, input logic pt);
      frame_q.push_back('{tx: 1'b0, busy: 1'b1, rd: 1'b1});
      for (int i = 0; i < 8; i++)
         frame_q.push_back('{tx: w[i], busy: 1'b1, rd: 1'b0});
      if (pe)
         frame_q.push_back('{tx: logic'(($countones(w) % 2) == 1) ^ pt, busy: 1'b1, rd: 1'b0});
      frame_q.push_back('{tx: 1'b1, busy: 1'b1, rd: 1'b0});
   endtask

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] w;
      if (!rst_n) begin
         frame_q.delete();
         exp_e = IDLE_E;
      end else begin
         if (frame_q.size() == 0 && !fifo_empty) begin
            build_frame(fifo_data, par_en, par_typ);
            w = fq.pop_front();
         end
         if (frame_q.size() > 0)
            exp_e = frame_q.pop_front();
         else
            exp_e = IDLE_E;
      end
   end

   always @(negedge clk) begin
      check("tx_out", 32'(tx_out), 32'(exp_e.tx));
      check("busy", 32'(busy), 32'(exp_e.busy));
      check("rd_inc", 32'(rd_inc), 32'(exp_e.rd));
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
   end

   task automatic push(input logic [7:0] w);
      @(posedge clk);
      #2;
      fq.push_back(w);
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (rd_inc) begin
            ok = 1'b1;
            break;
         end
      end
      check("rd_inc_seen", 32'(ok), 32'd1);
   endtask

   task automatic sample_frame(input int n, output logic [31:0] bits, output int busy_n, output int rd_n);
      bit ok;
      bits = '0;
      busy_n = 0;
      rd_n = 0;
      wait_rd(ok);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bits[i] = tx_out;
            busy_n += int'(busy);
            rd_n   += int'(rd_inc);
         end
      end
   endtask

   initial begin
      logic [31:0] bits;
      int          bn;
      int          rn;
      bit          ok;

      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_tx", 32'(tx_out), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rd", 32'(rd_inc), 32'd0);

      push(8'hA5);
      sample_frame(10, bits, bn, rn);
      check("a5_line", bits, 32'b1101001010);
      check("a5_busy", 32'(bn), 32'd10);
      check("a5_pops", 32'(rn), 32'd1);
      @(negedge clk);
      check("a5_after_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);

      @(posedge clk); #2 par_en = 1'b1; par_typ = 1'b0;
      push(8'hA5);
      sample_frame(11, bits, bn, rn);
      check("a5_even_line", bits, 32'b10101001010);
      check("a5_even_busy", 32'(bn), 32'd11);
      repeat (3) @(negedge clk);

      @(posedge clk); #2 par_typ = 1'b1;
      push(8'hA5);
      sample_frame(11, bits, bn, rn);
      check("a5_odd_line", bits, 32'b11101001010);
      repeat (3) @(negedge clk);

      @(posedge clk); #2 par_en = 1'b0; par_typ = 1'b0;
      fq.push_back(8'h01);
      fq.push_back(8'h80);
      fq.push_back(8'hFF);
      sample_frame(30, bits, bn, rn);
      check("b2b_line", bits, {2'b00, 10'b1111111110, 10'b1100000000, 10'b1000000010});
      check("b2b_busy", 32'(bn), 32'd30);
      check("b2b_pops", 32'(rn), 32'd3);
      @(negedge clk);
      check("b2b_after_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);

      @(posedge clk); #2 par_en = 1'b1; par_typ = 1'b0;
      push(8'h0F);
      fork
         sample_frame(11, bits, bn, rn);
         begin
            repeat (4) @(posedge clk);
            #2 par_typ = 1'b1;
         end
      join
      check("0f_latched_par_line", bits, 32'b10000011110);
      repeat (3) @(negedge clk);

      @(posedge clk); #2 par_en = 1'b0; par_typ = 1'b0;
      fq.push_back(8'hC3);
      wait_rd(ok);
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_tx", 32'(tx_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd", 32'(rd_inc), 32'd0);
      fq.push_back(8'h5A);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      sample_frame(10, bits, bn, rn);
      check("5a_after_rst_line", bits, 32'b1010110100);
      check("5a_after_rst_pops", 32'(rn), 32'd1);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the async FIFO, in the UART TX clock domain.
- Pops one word whenever the FIFO is not empty and the transmitter is free, then serializes it as a UART frame: start, data LSB-first, optional parity, stop.
- Serial timing is one bit per clock; the TX clock is the baud clock.
- Drives the FIFO read-increment input directly and consumes the FIFO's empty flag and read data bus.

Parameters:
- D_SIZE, 8, data word width; must match the FIFO D_SIZE.

Ports:
- i_clk  input  1  TX/baud clock; all logic on rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_fifo_empty  input  1  FIFO empty flag (read-domain synchronized).
- i_fifo_data  input  D_SIZE  FIFO read data; valid whenever i_fifo_empty=0 (first-word fall-through).
- i_par_en  input  1  1 = insert parity bit.
- i_par_typ  input  1  0 = even parity, 1 = odd parity.
- o_fifo_rd_inc  output  1  FIFO read-increment; one-cycle pulse per popped word.
- o_tx_out  output  1  serial line; idle high.
- o_busy  output  1  high from start bit through stop bit.

Behaviour:
- Interface: single clock i_clk; reset i_rstn is asynchronous, active-low.
- Reset values: o_tx_out=1, o_busy=0, o_fifo_rd_inc=0, state=IDLE, bit counter=0, shift register=0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_out=1, o_busy=0.
  - At an edge with i_fifo_empty=0:
    - capture i_fifo_data into the shift register;
    - latch i_par_en and i_par_typ;
    - compute parity = ^data XOR par_typ;
    - set o_fifo_rd_inc=1 for exactly the next cycle;
    - go to START.
- START: o_tx_out=0 and o_busy=1 for 1 cycle, then DATA with bit counter=0.
- DATA:
  - Shows data[counter] on o_tx_out for 1 cycle each, LSB first, D_SIZE cycles.
  - After counter reaches D_SIZE-1: go to PARITY if the latched par_en=1, otherwise STOP.
- PARITY: o_tx_out = latched parity for 1 cycle, then STOP.
- STOP: o_tx_out=1 for 1 cycle.
  - At the edge leaving STOP, if i_fifo_empty=0: capture the next word exactly as in IDLE, pulse o_fifo_rd_inc, and go straight to START. There is no idle bit between frames and o_busy stays 1.
  - Otherwise go to IDLE with o_busy=0.
- Frame length is D_SIZE+2 cycles, or D_SIZE+3 cycles with parity.
- First-bit latency: the start bit appears on o_tx_out in the cycle right after the capture edge.
- Pops:
  - Exactly one o_fifo_rd_inc pulse per frame, asserted during the start-bit cycle.
  - Never pulses while i_fifo_empty=1.
  - Never pulses twice in one frame.
- i_fifo_empty is sampled only in IDLE and at the STOP exit edge. Changes mid-frame are ignored.
- i_par_en and i_par_typ are latched at capture. Changes mid-frame do not affect the current frame.
- Reset asserted mid-frame: outputs return immediately to reset values. A word already popped is lost; this is accepted. Transmission restarts from IDLE after release.
- FIFO full or overflow is the writer's concern and is not visible here.

Test Plan:
- Reset, FIFO empty -> o_tx_out=1, o_busy=0, o_fifo_rd_inc=0 indefinitely.
- Word 0xA5, par_en=0 -> one rd_inc pulse; line shows 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; then IDLE.
- Word 0xA5, par_en=1, par_typ=0 -> parity bit 0, 11-cycle frame. Same word with par_typ=1 -> parity bit 1.
- Three words 0x01, 0x80, 0xFF queued, par_en=0 -> three back-to-back 10-cycle frames with no idle gap; exactly 3 rd_inc pulses; busy continuously high for 30 cycles.
- par_typ toggled during the DATA bits of a 0x0F frame with par_en=1 -> parity bit uses the value latched at capture.
- i_rstn asserted at DATA bit 3 -> o_tx_out=1 and busy=0 immediately. After release with FIFO non-empty, a new full frame starts with a fresh rd_inc.
